// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand modes and the sequencer state encoding.
package alu_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when the operand has to be inverted-and-incremented for this mode.
  // The reserved encoding 2'b11 falls through as pass.
  function automatic logic needs_invert(input logic [1:0] mode, input logic sign);
    return (mode == MODE_NEG) || ((mode == MODE_ABS) && sign);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple-carry incrementer slice: sum = (a ^ {CHUNK{inv}}) + c_in.
module chunk_adder #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic             inv,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out
);

  logic [CHUNK-1:0] w_a;
  logic [CHUNK:0]   w_c;

  assign w_a    = a ^ {CHUNK{inv}};
  assign w_c[0] = c_in;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    fullAdder u_fa (
      .a    (w_a[i]),
      .b    (1'b0),
      .cin  (w_c[i]),
      .sum  (sum[i]),
      .cout (w_c[i+1])
    );
  end

  assign c_out = w_c[CHUNK];

endmodule

// File: rtl/fullAdder.sv
// Single-bit full adder cell from the datapath cell library.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_twos_complement.sv
// Multi-cycle two's-complement unit: pass / negate / abs, CHUNK bits per cycle,
// valid/ready on both sides, overflow on negating the most-negative value.
module seq_twos_complement
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(1) << (WIDTH - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("seq_twos_complement: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic             r_inv;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_z;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_inv_in;
  logic [CHUNK-1:0] w_slice;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic             w_last;

  assign w_inv_in = needs_invert(mode, x[WIDTH-1]);
  assign w_last   = (r_cnt == CW'(NCHUNK - 1));

  // Select the operand slice addressed by the chunk counter.
  always_comb begin
    w_slice = '0;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (r_cnt == CW'(k)) w_slice = r_x[k*CHUNK +: CHUNK];
    end
  end

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a     (w_slice),
    .inv   (r_inv),
    .c_in  (r_carry),
    .sum   (w_sum),
    .c_out (w_cout)
  );

  // Sequencer: accept operand, walk the slices carrying between them, hold result.
  // Mode is reduced to the single invert bit at acceptance; nothing else needs it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_inv       <= 1'b0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_z         <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x        <= x;
            r_inv      <= w_inv_in;
            r_carry    <= w_inv_in;
            r_cnt      <= '0;
            r_z        <= '0;
            r_ovf      <= w_inv_in && (x == MOST_NEG);
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          for (int unsigned k = 0; k < NCHUNK; k++) begin
            if (r_cnt == CW'(k)) r_z[k*CHUNK +: CHUNK] <= w_sum;
          end
          r_carry <= w_cout;
          if (w_last) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign z         = r_z;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_seq_twos_complement.sv
// Self-checking bench for seq_twos_complement: table-driven vectors on a 64/16
// instance, hand-written handshake/reset sequences, and random sweeps on
// several WIDTH/CHUNK configurations against a behavioural -x/abs model.
module tb_seq_twos_complement;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int sweep_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- main instance, WIDTH=64 CHUNK=16 ----------------
  localparam int NC_MAIN = 4;

  logic        rst, rst_s;
  logic        in_valid, in_ready, out_valid, out_ready, ovf;
  logic [63:0] x, z;
  logic [1:0]  mode;

  seq_twos_complement #(.WIDTH(64), .CHUNK(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .ovf       (ovf)
  );

  typedef struct {
    logic [63:0] z;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [63:0] x;
    logic [63:0] z;
    logic        ovf;
  } vec_t;

  // Offer one operand, wait (bounded) for the result, check latency and value.
  // If release is set, out_ready is assumed high and the return to IDLE is checked.
  task automatic run_txn(input string name, input logic [1:0] m, input logic [63:0] xv,
                         input logic [63:0] ez, input logic eo, input logic release_chk);
    int   cyc;
    exp_t e;
    sb.push_back('{z: ez, ovf: eo});
    check({name, " in_ready"}, {63'b0, in_ready}, 64'd1);
    in_valid = 1'b1;
    x        = xv;
    mode     = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x        = {$urandom(), $urandom()};
    mode     = 2'($urandom_range(0, 3));
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " latency"}, 64'(cyc), 64'(NC_MAIN + 1));
    e = sb.pop_front();
    check({name, " z"}, z, e.z);
    check({name, " ovf"}, {63'b0, ovf}, {63'b0, e.ovf});
    if (release_chk) begin
      @(posedge clk); #1;
      check({name, " drop"}, {63'b0, out_valid}, 64'd0);
      check({name, " idle"}, {63'b0, in_ready}, 64'd1);
    end
  endtask

  initial begin
    vec_t vecs[13];
    logic seen;
    int   guard;

    vecs[0]  = '{"pass",     2'b00, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[1]  = '{"neg1",     2'b01, 64'h1,                   64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[2]  = '{"neg10000", 2'b01, 64'h0000_0000_0001_0000, 64'hFFFF_FFFF_FFFF_0000, 1'b0};
    vecs[3]  = '{"neg0",     2'b01, 64'h0,                   64'h0,                   1'b0};
    vecs[4]  = '{"abs-5",    2'b10, 64'hFFFF_FFFF_FFFF_FFFB, 64'h5,                   1'b0};
    vecs[5]  = '{"abs7",     2'b10, 64'h7,                   64'h7,                   1'b0};
    vecs[6]  = '{"absmin",   2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1};
    vecs[7]  = '{"negmin",   2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1};
    vecs[8]  = '{"passmin",  2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0};
    vecs[9]  = '{"rsvd",     2'b11, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0};
    vecs[10] = '{"negmin+1", 2'b01, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[11] = '{"abshi",    2'b10, 64'hFFFF_0000_0000_0000, 64'h0001_0000_0000_0000, 1'b0};
    vecs[12] = '{"abs0",     2'b10, 64'h0,                   64'h0,                   1'b0};

    rst = 1'b1; rst_s = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; x = '0; mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; rst_s = 1'b0;
    check("rst in_ready", {63'b0, in_ready}, 64'd1);
    check("rst out_valid", {63'b0, out_valid}, 64'd0);
    check("rst z", z, 64'd0);
    check("rst ovf", {63'b0, ovf}, 64'd0);

    foreach (vecs[i]) run_txn(vecs[i].name, vecs[i].mode, vecs[i].x, vecs[i].z, vecs[i].ovf, 1'b1);

    // Backpressure: result must hold and new offers must be ignored.
    out_ready = 1'b0;
    run_txn("bp", 2'b01, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      x        = {$urandom(), $urandom()};
      mode     = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      check("bp hold valid", {63'b0, out_valid}, 64'd1);
      check("bp hold z", z, 64'hFFFF_FFFF_FFFF_FFFD);
      check("bp in_ready", {63'b0, in_ready}, 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release valid", {63'b0, out_valid}, 64'd0);
    check("bp release idle", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    check("bp no spurious", {63'b0, in_ready}, 64'd1);

    // Reset during the second BUSY cycle aborts the transaction.
    in_valid = 1'b1; x = 64'd9; mode = 2'b01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort in_ready", {63'b0, in_ready}, 64'd1);
    check("abort out_valid", {63'b0, out_valid}, 64'd0);
    check("abort z", z, 64'd0);
    check("abort ovf", {63'b0, ovf}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check("abort no valid", {63'b0, seen}, 64'd0);
    run_txn("after abort", 2'b00, 64'hAA, 64'hAA, 1'b0, 1'b1);

    guard = 0;
    while (sweep_done < 4 && guard < 60000) begin
      @(posedge clk);
      guard++;
    end
    check("sweeps finished", 64'(sweep_done), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- parameter sweep instances ----------------
  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int W   = (g == 3) ? 32 : 64;
    localparam int C   = (g == 0) ? 1 : (g == 1) ? 8 : (g == 2) ? 64 : 4;
    localparam int NC  = W / C;
    localparam int NTX = (C == 1) ? 250 : 1000;

    logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_ovf;
    logic [W-1:0] s_x, s_z;
    logic [1:0]   s_mode;

    seq_twos_complement #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk       (clk),
      .rst       (rst_s),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .x         (s_x),
      .mode      (s_mode),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .z         (s_z),
      .ovf       (s_ovf)
    );

    initial begin
      logic [W:0]   q[$];
      logic [W:0]   e;
      logic [W-1:0] rx, mn, ex;
      logic [63:0]  r64;
      logic [1:0]   m;
      logic         inv;
      int           cyc;

      s_in_valid = 1'b0; s_out_ready = 1'b1; s_x = '0; s_mode = 2'b00;
      repeat (4) @(posedge clk);
      #1;
      mn = '0;
      mn[W-1] = 1'b1;
      for (int n = 0; n < NTX; n++) begin
        r64 = {$urandom(), $urandom()};
        rx  = r64[W-1:0];
        m   = 2'($urandom_range(0, 3));
        if (n == 0) rx = '0;
        if (n == 1) rx = mn;
        if (n == 2) rx = '1;
        if (n == 3) rx = 1;
        if (n < 4) m = (n % 2 == 1) ? 2'b10 : 2'b01;
        inv = (m == 2'b01) || (m == 2'b10 && rx[W-1]);
        ex  = inv ? ('0 - rx) : rx;
        q.push_back({inv && (rx == mn), ex});

        check($sformatf("sw%0d in_ready", g), {63'b0, s_in_ready}, 64'd1);
        s_in_valid = 1'b1; s_x = rx; s_mode = m;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        r64 = {$urandom(), $urandom()};
        s_x = r64[W-1:0];
        cyc = 1;
        while (!s_out_valid && cyc < 200) begin
          @(posedge clk); #1;
          cyc++;
        end
        check($sformatf("sw%0d latency", g), 64'(cyc), 64'(NC + 1));
        e = q.pop_front();
        check($sformatf("sw%0d z x=%h m=%0d", g, rx, m), 64'(s_z), 64'(e[W-1:0]));
        check($sformatf("sw%0d ovf x=%h m=%0d", g, rx, m), {63'b0, s_ovf}, {63'b0, e[W]});
        @(posedge clk); #1;
      end
      sweep_done++;
    end
  end

endmodule
